// File: rtl/apb4_pkg.sv
// Shared APB4 requester types: FSM state encoding and pprot bit positions.
// Types only; no latency. No flow control.
// Nothing here depends on the APB4_MASTER_TIMEOUT_EN build option.
package apb4_pkg;

    localparam int APB4_PROT_W = 3;

    localparam logic [APB4_PROT_W-1:0] APB4_PROT_PRIV    = 3'b001;
    localparam logic [APB4_PROT_W-1:0] APB4_PROT_NONSEC  = 3'b010;
    localparam logic [APB4_PROT_W-1:0] APB4_PROT_INSTR   = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb4_mst_state_e;

endpackage

// File: rtl/apb4_master.sv
// Single-outstanding APB4 requester: one SETUP/ACCESS transfer per accepted request.
// Latency: accept -> rsp_valid_o 3 cycles with a zero-wait completer, +1 per wait state.
// Backpressure: req_ready_o only in IDLE; response held until rsp_ready_i. Option: APB4_MASTER_TIMEOUT_EN.
module apb4_master
    import apb4_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          pclk_i,
    input  logic                          presetn_i,

    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0]     req_addr_i,
    input  logic                          req_write_i,
    input  logic [APB_DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [APB_DATA_WIDTH/8-1:0]   req_strb_i,
    input  logic [APB4_PROT_W-1:0]        req_prot_i,

    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                          rsp_err_o,

    output logic [APB_ADDR_WIDTH-1:0]     paddr_o,
    output logic [APB4_PROT_W-1:0]        pprot_o,
    output logic                          pwrite_o,
    output logic [APB_DATA_WIDTH-1:0]     pwdata_o,
    output logic [APB_DATA_WIDTH/8-1:0]   pstrb_o,
    output logic                          psel_o,
    output logic                          penable_o,
    input  logic [APB_DATA_WIDTH-1:0]     prdata_i,
    input  logic                          pready_i,
    input  logic                          pslverr_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb4_master: TIMEOUT_CYCLES must be >= 1");
    end

    apb4_mst_state_e state_q, state_d;
    logic            accept;
    logic            done;
    logic            timeout_hit;

    assign accept      = (state_q == IDLE) && req_valid_i;
    assign done        = (state_q == ACCESS) && pready_i;
    assign req_ready_o = (state_q == IDLE);

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    // Fires on the edge that ends the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    assign timeout_hit = (state_q == ACCESS) && !pready_i &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            wait_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            wait_cnt_q <= '0;
        end else if ((state_q == ACCESS) && !pready_i) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_i || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q     <= IDLE;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            paddr_o     <= '0;
            pprot_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
        end else begin
            state_q     <= state_d;
            // Bus controls are registered from the next state so they change with it.
            psel_o      <= (state_d == SETUP) || (state_d == ACCESS);
            penable_o   <= (state_d == ACCESS);
            rsp_valid_o <= (state_d == RESP);

            if (accept) begin
                paddr_o  <= req_addr_i;
                pprot_o  <= req_prot_i;
                pwrite_o <= req_write_i;
                pwdata_o <= req_wdata_i;
                pstrb_o  <= req_write_i ? req_strb_i : '0;
            end

            if (done) begin
                rsp_err_o   <= pslverr_i;
                rsp_rdata_o <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
            end else if (timeout_hit) begin
                rsp_err_o   <= 1'b1;
                rsp_rdata_o <= '0;
            end
        end
    end

endmodule
